// File: rtl/bandit_pkg.sv
// bandit_pkg: types and constants shared by the bandit agent and environment
package bandit_pkg;
  typedef logic [7:0] action_t;
  typedef logic signed [7:0] reward_t;
  typedef logic [7:0] prob_t;
  localparam action_t INVALID_ACTION = 8'd0;
  localparam reward_t INVALID_REWARD = reward_t'(8'h80);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} env_state_t;
endpackage

// File: rtl/bandit_environment_if.sv
// bandit_environment_if: action, reward and probability-config channels between agent and environment
interface bandit_environment_if;
  import bandit_pkg::*;
  logic action_valid, action_ready, reward_valid, reward_ready, cfg_valid, cfg_ready;
  action_t action_data, cfg_addr;
  reward_t reward_data;
  prob_t cfg_data;
  modport master (
    output action_valid, action_data, reward_ready, cfg_valid, cfg_addr, cfg_data,
    input action_ready, reward_valid, reward_data, cfg_ready
  );
  modport slave (
    input action_valid, action_data, reward_ready, cfg_valid, cfg_addr, cfg_data,
    output action_ready, reward_valid, reward_data, cfg_ready
  );
endinterface

// File: rtl/bandit_lfsr.sv
// bandit_lfsr: right-shifting Galois LFSR, free-running while enabled
module bandit_lfsr #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] state
);
  always_ff @(posedge clock) begin
    if (reset) state <= SEED;
    else if (enable) state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end
  // an all-zero seed would lock the register at zero forever
  assert property (@(posedge clock) SEED != '0);
endmodule

// File: rtl/bandit_environment.sv
// bandit_environment: accepts an action, waits DELAY cycles, returns a Bernoulli reward from a per-action win table
module bandit_environment
  import bandit_pkg::*;
#(
  parameter int DELAY = 10,
  parameter reward_t WIN_REWARD = 8'sd64,
  parameter reward_t LOSE_REWARD = -8'sd32,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clock,
  input logic reset,
  bandit_environment_if.slave bus
);
  env_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  action_t action_q, action_d;
  reward_t reward_q, reward_d, outcome;
  logic valid_q, valid_d, ready_q, ready_d;
  prob_t prob_q [256];
  prob_t prob;
  logic [15:0] lfsr;
  logic accept, handshake, expire, win, unused_lfsr;

  bandit_lfsr #(.WIDTH(16), .TAPS(16'hB400), .SEED(SEED)) u_lfsr (
    .clock(clock),
    .reset(reset),
    .enable(1'b1),
    .state(lfsr)
  );

  assign accept = bus.action_valid & ready_q;
  assign handshake = valid_q & bus.reward_ready;
  assign expire = state_q == WAIT && cnt_q == '0;
  assign unused_lfsr = ^lfsr[15:8];

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q == IDLE && accept) ? WAIT :
              expire ? RESPOND :
              (state_q == RESPOND && handshake) ? IDLE : state_q;
  end

  // table lookup happens at WAIT exit so a config write on the accepting edge is honoured
  always_comb begin
    prob = prob_q[action_q];
    win = prob == 8'hFF || lfsr[7:0] < prob;
    outcome = action_q == INVALID_ACTION ? INVALID_REWARD : win ? WIN_REWARD : LOSE_REWARD;
    cnt_d = accept ? 8'(DELAY) : (state_q == WAIT && cnt_q != '0) ? cnt_q - 8'd1 : cnt_q;
    action_d = accept ? bus.action_data : action_q;
    reward_d = expire ? outcome : reward_q;
    valid_d = state_q == RESPOND && !handshake;
    ready_d = state_d == IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      action_q <= '0;
      reward_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      action_q <= action_d;
      reward_q <= reward_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) prob_q[i] <= '0;
    end else if (bus.cfg_valid && ready_q && bus.cfg_addr != INVALID_ACTION) begin
      prob_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.action_ready = ready_q;
  assign bus.cfg_ready = ready_q;
  assign bus.reward_valid = valid_q;
  assign bus.reward_data = reward_q;
endmodule

// File: tb/tb_bandit_environment.sv
// tb_bandit_environment: scoreboard bench for the bandit environment handshake, outcome rule and reset behaviour
module tb_bandit_environment;
  import bandit_pkg::*;
  localparam int LAT = 12;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  bandit_environment_if bus();
  bandit_environment #(.DELAY(10), .WIN_REWARD(8'sd64), .LOSE_REWARD(-8'sd32), .SEED(16'hACE1)) dut (
    .clock(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_checks = 0, n_fail = 0;
  reward_t exp_q[$];

  task automatic cfg_write(input action_t a, input prob_t d);
    int j = 0;
    while (!bus.cfg_ready && j < 100) begin @(negedge clk); j++; end
    bus.cfg_valid = 1; bus.cfg_addr = a; bus.cfg_data = d;
    @(posedge clk); @(negedge clk);
    bus.cfg_valid = 0;
  endtask

  task automatic do_pull(input action_t a, input bit cfg_en, input action_t ca, input prob_t cd,
                         output int lat, output reward_t r, output bit ok);
    int j;
    bit rr;
    ok = 1; j = 0;
    while (!bus.action_ready && j < 100) begin @(negedge clk); j++; end
    if (!bus.action_ready) ok = 0;
    bus.action_valid = 1; bus.action_data = a;
    bus.cfg_valid = cfg_en; bus.cfg_addr = ca; bus.cfg_data = cd;
    @(posedge clk); @(negedge clk);
    bus.action_valid = 0; bus.cfg_valid = 0;
    j = 0;
    while (!bus.reward_valid && j < 1000) begin @(negedge clk); j++; end
    lat = j; r = bus.reward_data;
    if (!bus.reward_valid) ok = 0;
    rr = bus.reward_ready; bus.reward_ready = 1;
    @(posedge clk); @(negedge clk);
    bus.reward_ready = rr;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.action_ready !== 1'b0 || bus.reward_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: action_ready=%b reward_valid=%b, want 0 0", bus.action_ready, bus.reward_valid);
      end
    end
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (bus.action_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_action_ready: got %b want 1", bus.action_ready); end
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cfg_ready: got %b want 1", bus.cfg_ready); end
    n_checks++;
    if (bus.reward_data !== 8'd0) begin n_fail++; $display("FAIL post_reset_reward_data: got %0d want 0", bus.reward_data); end
  endtask

  task automatic test_win_lose();
    int lat; reward_t r, e; bit ok;
    action_t acts[2] = '{8'd1, 8'd2};
    reward_t exps[2] = '{8'sd64, -8'sd32};
    cfg_write(8'd1, 8'd255);
    cfg_write(8'd2, 8'd0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exps[i]);
      do_pull(acts[i], 0, 8'd0, 8'd0, lat, r, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL win_lose_timeout: action %0d got no handshake, want one", acts[i]); end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL win_lose_latency: action %0d latency %0d want %0d", acts[i], lat, LAT); end
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL win_lose_reward: action %0d got %0d want %0d", acts[i], r, e); end
    end
  endtask

  task automatic test_invalid();
    int lat; reward_t r, e; bit ok;
    cfg_write(8'd0, 8'd255);
    exp_q.push_back(INVALID_REWARD);
    do_pull(8'd0, 0, 8'd0, 8'd0, lat, r, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL invalid_action: ok=%b got %0d want %0d", ok, r, e); end
  endtask

  task automatic test_back_to_back();
    int lat; reward_t r, e; bit ok;
    bus.reward_ready = 1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'sd64);
      do_pull(8'd3, i == 0, 8'd3, 8'd255, lat, r, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || r !== e || lat != LAT) begin
        n_fail++; $display("FAIL back_to_back_%0d: ok=%b reward %0d latency %0d want %0d latency %0d", i, ok, r, lat, e, LAT);
      end
      n_checks++;
      if (bus.reward_valid !== 1'b0 || bus.action_ready !== 1'b1) begin
        n_fail++; $display("FAIL back_to_back_pulse_%0d: reward_valid=%b action_ready=%b want 0 1", i, bus.reward_valid, bus.action_ready);
      end
    end
    bus.reward_ready = 0;
  endtask

  task automatic test_backpressure();
    int j = 0, bad = 0; reward_t e;
    exp_q.push_back(8'sd64);
    bus.action_valid = 1; bus.action_data = 8'd1;
    @(posedge clk); @(negedge clk);
    bus.action_valid = 0;
    while (!bus.reward_valid && j < 1000) begin @(negedge clk); j++; end
    e = exp_q.pop_front();
    n_checks++;
    if (!bus.reward_valid) begin n_fail++; $display("FAIL backpressure_timeout: reward_valid %b want 1", bus.reward_valid); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (bus.reward_valid !== 1'b1 || bus.reward_data !== e || bus.action_ready !== 1'b0) begin
        n_fail++; $display("FAIL backpressure_hold_%0d: valid=%b data=%0d action_ready=%b want 1 %0d 0", i, bus.reward_valid, bus.reward_data, bus.action_ready, e);
      end
      bus.action_valid = i == 5; bus.action_data = 8'd2;
      @(negedge clk);
    end
    bus.action_valid = 0;
    bus.reward_ready = 1;
    @(posedge clk); @(negedge clk);
    bus.reward_ready = 0;
    n_checks++;
    if (bus.action_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release: action_ready %b want 1", bus.action_ready); end
    repeat (30) begin @(negedge clk); if (bus.reward_valid !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL backpressure_ghost: %0d cycles of reward_valid, want 0", bad); end
  endtask

  task automatic test_statistics();
    int lat, wins = 0, bad = 0; reward_t r; bit ok;
    cfg_write(8'd5, 8'd64);
    for (int i = 0; i < 4096; i++) begin
      do_pull(8'd5, 0, 8'd0, 8'd0, lat, r, ok);
      if (!ok) bad++;
      if (r === 8'sd64) wins++;
      else if (r !== -8'sd32) bad++;
    end
    $display("statistics: %0d wins of 4096", wins);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL statistics_values: %0d bad pulls, want 0", bad); end
    n_checks++;
    if (wins < 928 || wins > 1120) begin n_fail++; $display("FAIL statistics_wins: got %0d want 928..1120", wins); end
  endtask

  task automatic test_reset_in_wait();
    int lat, bad = 0; reward_t r, e; bit ok;
    bus.action_valid = 1; bus.action_data = 8'd1;
    @(posedge clk); @(negedge clk);
    bus.action_valid = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (30) begin @(negedge clk); if (bus.reward_valid !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_in_wait_dropped: %0d cycles of reward_valid, want 0", bad); end
    exp_q.push_back(-8'sd32);
    do_pull(8'd1, 0, 8'd0, 8'd0, lat, r, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL reset_in_wait_table: ok=%b got %0d want %0d", ok, r, e); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.action_valid = 0; bus.action_data = 0; bus.reward_ready = 0;
    bus.cfg_valid = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
    test_reset();
    test_win_lose();
    test_invalid();
    test_back_to_back();
    test_backpressure();
    test_statistics();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
